memory_round_ctrl: RTL and testbench
====================================

// Module: memory_round_ctrl
// PURPOSE
//  Round sequencer for the memory game; sits directly upstream of the score/display stage.
//  Generates a pseudo-random digit sequence, presents it one digit at a time, then accepts
//  player guesses from switches + key, judging each guess as present/absent in the sequence.
//  Drives per-guess strobe + exist verdict and the display_state mode used by the display stage.
// PARAMETERS
//  SEQ_LEN       4     digits per round, legal 1..8
//  SHOW_TICKS    1000  tick pulses each digit is shown
//  GAP_TICKS     250   tick pulses of blank after each digit
//  RESULT_TICKS  2000  tick pulses in RESULT before returning to IDLE
// PORTS
//  clk           in   1  system clock
//  resetn        in   1  reset, asynchronous, active-low
//  tick          in   1  1-cycle timing enable strobe (nominally 1 kHz)
//  start         in   1  1-cycle start request (debounced, clk-synchronous)
//  key_n         in   1  guess button, active-low, debounced, asynchronous to clk
//  sw            in   4  guessed digit
//  show_digit    out  4  digit currently presented (0 when blank)
//  show_valid    out  1  1 while show_digit is a live sequence digit
//  guess_strobe  out  1  1-cycle pulse per accepted guess
//  exist         out  1  verdict of last guess; valid from guess_strobe until next strobe
//  guess_cnt     out  4  guesses accepted this round
//  display_state out  3  0=SCORE 1=SHOW 2=GUESS 3=RESULT
//  round_done    out  1  1-cycle pulse on entry to RESULT
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0; stored digits 0;
//   LFSR=16'hACE1; tick counter 0; key synchroniser flops 1.
//  LFSR: 16-bit Fibonacci, advances every clk in every state;
//   fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0],fb}.
//  Digit map: n=l[3:0]; digit = (n<10) ? n : n-6 (always 0..9).
//  FSM:
//   IDLE  : display_state=0. start=1 -> GEN. start ignored in all other states.
//   GEN   : SEQ_LEN cycles; cycle i stores mapped digit into seq[i]; then SHOW, idx=0.
//   SHOW  : display_state=1, show_valid=1, show_digit=seq[idx]; counts tick pulses;
//           on tick with count==SHOW_TICKS-1 -> GAP, count cleared.
//   GAP   : display_state=1, show_valid=0, show_digit=0; on tick with count==GAP_TICKS-1:
//           idx<SEQ_LEN-1 -> idx+1, SHOW; else -> GUESS, guess_cnt=0.
//   GUESS : display_state=2. Press = synced key_n 1->0 (2-FF sync, then edge detect).
//           On press: exist <= (sw equals any seq[0..SEQ_LEN-1]); guess_strobe=1 next cycle
//           together with updated exist; guess_cnt+1. When guess_cnt reaches SEQ_LEN -> RESULT.
//   RESULT: display_state=3, round_done pulses on entry; after RESULT_TICKS ticks -> IDLE.
//  Latency: key_n fall -> guess_strobe 3 clk (2 sync + edge reg), exist updates same cycle.
//  sw>=10 never matches -> exist=0. Repeated guesses of same digit each count and judge.
//  Presses outside GUESS are discarded (not queued). Held key yields exactly one press.
//  Counters compare only when tick=1; tick absent -> state holds indefinitely.
//  exist and guess_cnt hold through RESULT/IDLE; guess_cnt clears on entry to GUESS.
//  resetn mid-round: immediate return to IDLE, no strobe/round_done emitted.
// TESTING
//  (bench params SEQ_LEN=4 SHOW=3 GAP=2 RESULT=4, tick=1 every cycle)
//  1 Reset then start -> GEN 4 cyc; seq[] matches LFSR/digit-map model from seed ACE1;
//    show_valid high 3 cyc / low 2 cyc per digit, 20 cyc total, then display_state=2.
//  2 In GUESS set sw=seq[2], drop key_n -> guess_strobe 3 clk later, exist=1, guess_cnt=1.
//  3 sw=4'hF and sw=digit absent from seq -> exist=0 on each strobe; key held low 50 cyc
//    -> single strobe only.
//  4 Four presses -> round_done 1 pulse, display_state=3 for 4 ticks, then 0; exist held.
//  5 key presses during SHOW and start pulses during GUESS -> no strobe, no state change.
//  6 resetn low mid-SHOW and mid-GUESS -> outputs 0 asynchronously, LFSR=ACE1, state IDLE.

Source files
------------

// File: rtl/memory_round_ctrl.sv
// memory_round_ctrl: memory-game round sequencer (generate, show, guess, result).
// Ports: clk/resetn, tick/start/key_n/sw in; show_*, guess_*, exist, display_state, round_done out.
module memory_round_ctrl #(
  parameter int SEQ_LEN      = 4,
  parameter int SHOW_TICKS   = 1000,
  parameter int GAP_TICKS    = 250,
  parameter int RESULT_TICKS = 2000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic [3:0] show_digit,
  output logic       show_valid,
  output logic       guess_strobe,
  output logic       exist,
  output logic [3:0] guess_cnt,
  output logic [2:0] display_state,
  output logic       round_done
);

  localparam int MAX_A = (SHOW_TICKS > GAP_TICKS) ?
                         SHOW_TICKS : GAP_TICKS;
  localparam int MAX_T = (MAX_A > RESULT_TICKS) ?
                         MAX_A : RESULT_TICKS;
  localparam int CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(RESULT_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SEQ_LEN - 1);
  localparam logic [3:0]    CNT_LAST  = 4'(SEQ_LEN - 1);

  localparam logic [2:0] DS_SCORE  = 3'd0;
  localparam logic [2:0] DS_SHOW   = 3'd1;
  localparam logic [2:0] DS_GUESS  = 3'd2;
  localparam logic [2:0] DS_RESULT = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_GAP,
    S_GUESS,
    S_RESULT
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [3:0]    seq [SEQ_LEN];
  logic [15:0]   lfsr;
  logic [3:0]    nib;
  logic [3:0]    digit;
  logic          hit;
  logic          key_s1;
  logic          key_s2;
  logic          key_d;
  logic          press;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Fold 10..15 down onto 4..9 so every digit is decimal.
  assign nib   = lfsr[3:0];
  assign digit = (nib < 4'd10) ? nib : nib - 4'd6;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_d  <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  // Falling edge of the synchronised key; a held key gives one press.
  assign press = key_d & ~key_s2;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (seq[i] == sw) hit = 1'b1;
    end
    if (sw > 4'd9) hit = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      for (int i = 0; i < SEQ_LEN; i++) seq[i] <= 4'd0;
      show_digit    <= 4'd0;
      show_valid    <= 1'b0;
      guess_strobe  <= 1'b0;
      exist         <= 1'b0;
      guess_cnt     <= 4'd0;
      display_state <= DS_SCORE;
      round_done    <= 1'b0;
    end else begin
      guess_strobe <= 1'b0;
      round_done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_GEN;
            idx   <= '0;
          end
        end
        S_GEN: begin
          seq[idx] <= digit;
          if (idx == IDX_LAST) begin
            state         <= S_SHOW;
            idx           <= '0;
            cnt           <= '0;
            display_state <= DS_SHOW;
            show_valid    <= 1'b1;
            // seq[0] is only written this cycle when SEQ_LEN is 1.
            show_digit    <= (SEQ_LEN == 1) ? digit : seq[0];
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_SHOW: begin
          if (tick) begin
            if (cnt == SHOW_LAST) begin
              state      <= S_GAP;
              cnt        <= '0;
              show_valid <= 1'b0;
              show_digit <= 4'd0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (idx == IDX_LAST) begin
                state         <= S_GUESS;
                guess_cnt     <= 4'd0;
                display_state <= DS_GUESS;
              end else begin
                state      <= S_SHOW;
                idx        <= idx + IW'(1);
                show_valid <= 1'b1;
                show_digit <= seq[idx + IW'(1)];
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_GUESS: begin
          if (press) begin
            guess_strobe <= 1'b1;
            exist        <= hit;
            guess_cnt    <= guess_cnt + 4'd1;
            if (guess_cnt == CNT_LAST) begin
              state         <= S_RESULT;
              cnt           <= '0;
              round_done    <= 1'b1;
              display_state <= DS_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (tick) begin
            if (cnt == RES_LAST) begin
              state         <= S_IDLE;
              cnt           <= '0;
              display_state <= DS_SCORE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_round_ctrl.sv
// tb_memory_round_ctrl: directed bench for memory_round_ctrl.
// SEQ_LEN=4 SHOW=3 GAP=2 RESULT=4, tick high every cycle.
module tb_memory_round_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] sw = 4'd0;
  logic [3:0] show_digit;
  logic       show_valid;
  logic       guess_strobe;
  logic       exist;
  logic [3:0] guess_cnt;
  logic [2:0] display_state;
  logic       round_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] m;
  logic [3:0]  exp_seq [4];

  typedef struct {
    int         kind;
    int         idx;
    logic [3:0] lit;
    logic       ex;
    logic [3:0] cnt;
    logic       done;
    int         hold;
  } gvec_t;

  gvec_t gv [4];

  memory_round_ctrl #(
    .SEQ_LEN(4),
    .SHOW_TICKS(3),
    .GAP_TICKS(2),
    .RESULT_TICKS(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .tick(tick),
    .start(start),
    .key_n(key_n),
    .sw(sw),
    .show_digit(show_digit),
    .show_valid(show_valid),
    .guess_strobe(guess_strobe),
    .exist(exist),
    .guess_cnt(guess_cnt),
    .display_state(display_state),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= 16'hACE1;
    else m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string n,
                      input logic a, input logic r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask

  task automatic chk3(input string n,
                      input logic [2:0] a, input logic [2:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask

  task automatic chk4(input string n,
                      input logic [3:0] a, input logic [3:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask

  task automatic chki(input string n, input int a, input int r);
    checks++;
    if (a != r) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dmap(input logic [15:0] l);
    logic [3:0] n;
    n = l[3:0];
    return (n < 4'd10) ? n : n - 4'd6;
  endfunction

  function automatic logic [3:0] absent_digit();
    for (int d = 0; d < 10; d++) begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4; i++)
        if (exp_seq[i] == 4'(d)) found = 1'b1;
      if (!found) return 4'(d);
    end
    return 4'd0;
  endfunction

  task automatic chk_zero(input string n);
    chk4({n, "_digit"}, show_digit, 4'd0);
    chk1({n, "_valid"}, show_valid, 1'b0);
    chk1({n, "_strobe"}, guess_strobe, 1'b0);
    chk1({n, "_exist"}, exist, 1'b0);
    chk4({n, "_cnt"}, guess_cnt, 4'd0);
    chk3({n, "_ds"}, display_state, 3'd0);
    chk1({n, "_done"}, round_done, 1'b0);
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_seq[i] = dmap(m);
      chk1("gen_valid", show_valid, 1'b0);
      step();
    end
  endtask

  task automatic run_show(input bit poke);
    int n = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 3; c++) begin
        if (poke && d == 1 && c == 0) key_n = 1'b0;
        if (poke && d == 2 && c == 0) key_n = 1'b1;
        chk1("show_valid", show_valid, 1'b1);
        chk4("show_digit", show_digit, exp_seq[d]);
        chk3("show_ds", display_state, 3'd1);
        step();
        if (guess_strobe) n++;
      end
      for (int c = 0; c < 2; c++) begin
        chk1("gap_valid", show_valid, 1'b0);
        chk4("gap_digit", show_digit, 4'd0);
        chk3("gap_ds", display_state, 3'd1);
        step();
        if (guess_strobe) n++;
      end
    end
    chki("show_no_strobe", n, 0);
    chk3("guess_ds", display_state, 3'd2);
    chk4("guess_cnt0", guess_cnt, 4'd0);
  endtask

  task automatic apply_guess(input gvec_t v);
    int n = 0;
    if (v.kind == 0) sw = exp_seq[v.idx];
    else if (v.kind == 1) sw = v.lit;
    else sw = absent_digit();
    key_n = 1'b0;
    step();
    chk1("strobe_early1", guess_strobe, 1'b0);
    step();
    chk1("strobe_early2", guess_strobe, 1'b0);
    step();
    chk1("strobe", guess_strobe, 1'b1);
    chk1("exist", exist, v.ex);
    chk4("guess_cnt", guess_cnt, v.cnt);
    chk1("round_done", round_done, v.done);
    chk3("press_ds", display_state, v.done ? 3'd3 : 3'd2);
    for (int i = 0; i < v.hold; i++) begin
      step();
      if (guess_strobe) n++;
    end
    key_n = 1'b1;
    if (v.hold > 0) begin
      for (int i = 0; i < 3; i++) begin
        step();
        if (guess_strobe) n++;
      end
      chki("held_single", n, 0);
    end
  endtask

  initial begin
    gv[0] = '{kind: 0, idx: 2, lit: 4'd0, ex: 1'b1,
              cnt: 4'd1, done: 1'b0, hold: 3};
    gv[1] = '{kind: 1, idx: 0, lit: 4'hF, ex: 1'b0,
              cnt: 4'd2, done: 1'b0, hold: 50};
    gv[2] = '{kind: 2, idx: 0, lit: 4'd0, ex: 1'b0,
              cnt: 4'd3, done: 1'b0, hold: 3};
    gv[3] = '{kind: 0, idx: 0, lit: 4'd0, ex: 1'b1,
              cnt: 4'd4, done: 1'b1, hold: 0};

    #12;
    chk_zero("reset");
    step();
    resetn = 1'b1;
    step();
    step();
    chk3("idle_ds", display_state, 3'd0);

    start_round();
    run_show(1'b0);
    for (int i = 0; i < 4; i++) apply_guess(gv[i]);
    for (int c = 1; c < 4; c++) begin
      step();
      chk3("result_ds", display_state, 3'd3);
      chk1("result_done_low", round_done, 1'b0);
    end
    step();
    chk3("back_idle_ds", display_state, 3'd0);
    chk1("exist_held", exist, 1'b1);
    chk4("cnt_held", guess_cnt, 4'd4);

    start_round();
    run_show(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk3("start_in_guess_ds", display_state, 3'd2);
    chk1("start_in_guess_valid", show_valid, 1'b0);
    chk4("start_in_guess_cnt", guess_cnt, 4'd0);
    apply_guess('{kind: 0, idx: 1, lit: 4'd0, ex: 1'b1,
                  cnt: 4'd1, done: 1'b0, hold: 3});

    resetn = 1'b0;
    #1;
    chk_zero("rst_guess");
    step();
    resetn = 1'b1;
    step();
    chk3("rst_guess_idle", display_state, 3'd0);

    start_round();
    step();
    chk1("pre_rst_valid", show_valid, 1'b1);
    resetn = 1'b0;
    #1;
    chk_zero("rst_show");
    step();
    resetn = 1'b1;
    step();

    start_round();
    run_show(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
